// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift_reg_piso / shift_reg_sipo pair.
package shift_reg_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam bit DIR_LSB_FIRST = 1'b1;
  localparam bit DIR_MSB_FIRST = 1'b0;

  // Frame length in bits: data word plus an optional trailing parity bit.
  function automatic int frame_len(input int size, input bit parity_en);
    return size + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/shift_reg_piso_if.sv
// Load handshake and serial output bundle for shift_reg_piso.
interface shift_reg_piso_if #(parameter int size = 8);
  logic            load_valid;
  logic            load_ready;
  logic [size-1:0] datain;
  logic            dataout;
  logic            dout_valid;
  logic            done;

  modport master (output load_valid, datain,
                  input  load_ready, dataout, dout_valid, done);
  modport slave  (input  load_valid, datain,
                  output load_ready, dataout, dout_valid, done);
endinterface

// File: rtl/shift_reg_bitcnt.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
module shift_reg_bitcnt #(
  parameter int WIDTH = 4,
  parameter int TC    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_cnt <= '0;
    else if (i_en)      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == WIDTH'(TC));
endmodule

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shifter with valid/ready load and back-to-back frames.
// Define SHIFT_REG_PISO_PARITY_EN to append an even-parity bit to every frame.
module shift_reg_piso
  import shift_reg_pkg::*;
#(
  parameter int size      = 8,
  parameter bit lsb_first = DIR_LSB_FIRST
) (
  input  logic clk,
  input  logic reset,
  shift_reg_piso_if.slave bus
);
`ifdef SHIFT_REG_PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = frame_len(size, PAR_EN);
  localparam int CW = $clog2(FL + 1);

  state_t          r_state;
  logic [size-1:0] r_sreg;
  logic            r_dout, r_dvalid, r_done;
`ifdef SHIFT_REG_PISO_PARITY_EN
  logic            r_par;
`endif

  logic [CW-1:0]   w_cnt;
  logic            w_tc, w_ready, w_accept, w_next_bit;
  logic [size-1:0] w_load_shifted, w_sreg_shifted;

  // Counter tracks the index of the bit currently on dataout.
  shift_reg_bitcnt #(.WIDTH(CW), .TC(FL-1)) u_bitcnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  ((r_state == SHIFT) && !w_tc),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  assign w_ready  = (r_state == IDLE) || w_tc;
  assign w_accept = bus.load_valid && w_ready;

  // The shift register always holds the bits not yet emitted, head first.
  assign w_load_shifted = (lsb_first == DIR_LSB_FIRST) ? (bus.datain >> 1) : (bus.datain << 1);
  assign w_sreg_shifted = (lsb_first == DIR_LSB_FIRST) ? (r_sreg >> 1) : (r_sreg << 1);

`ifdef SHIFT_REG_PISO_PARITY_EN
  assign w_next_bit = (w_cnt == CW'(size - 1)) ? r_par
                    : ((lsb_first == DIR_LSB_FIRST) ? r_sreg[0] : r_sreg[size-1]);
`else
  assign w_next_bit = (lsb_first == DIR_LSB_FIRST) ? r_sreg[0] : r_sreg[size-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sreg   <= '0;
      r_dout   <= 1'b0;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state  <= SHIFT;
      r_sreg   <= w_load_shifted;
      r_dout   <= (lsb_first == DIR_LSB_FIRST) ? bus.datain[0] : bus.datain[size-1];
      r_dvalid <= 1'b1;
      r_done   <= 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
      r_par    <= ^bus.datain;
`endif
    end else if (r_state == SHIFT) begin
      if (w_tc) begin
        r_state  <= IDLE;
        r_dout   <= 1'b0;
        r_dvalid <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        r_sreg <= w_sreg_shifted;
        r_dout <= w_next_bit;
        r_done <= (w_cnt == CW'(FL - 2));
      end
    end
  end

  assign bus.load_ready = w_ready;
  assign bus.dataout    = r_dout;
  assign bus.dout_valid = r_dvalid;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench: LSB-first and MSB-first instances, table-driven frames plus corner sequences.
module tb_shift_reg_piso;
  import shift_reg_pkg::*;

`ifdef SHIFT_REG_PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_reg_piso_if #(.size(8)) bus_l ();
  shift_reg_piso_if #(.size(8)) bus_m ();

  shift_reg_piso #(.size(8), .lsb_first(DIR_LSB_FIRST)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));
  shift_reg_piso #(.size(8), .lsb_first(DIR_MSB_FIRST)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));

  int tests = 0;
  int fails = 0;
  int done_cnt;

  // seq bit i is the i-th bit expected on dataout; par is the expected parity bit.
  typedef struct {
    bit         msb;
    logic [7:0] word;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit msb, input logic v, input logic [7:0] d);
    if (msb) begin bus_m.load_valid = v; bus_m.datain = d; end
    else     begin bus_l.load_valid = v; bus_l.datain = d; end
  endtask

  function automatic logic [3:0] outs(input bit msb);
    // {load_ready, dout_valid, dataout, done}
    if (msb) return {bus_m.load_ready, bus_m.dout_valid, bus_m.dataout, bus_m.done};
    return {bus_l.load_ready, bus_l.dout_valid, bus_l.dataout, bus_l.done};
  endfunction

  function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int i);
    return (i < 8) ? seq[i] : par;
  endfunction

  task automatic check_idle(input bit msb, input string name);
    check(name, 8'(outs(msb)), 8'b1000);
  endtask

  // Full frame from IDLE: accept, check every bit, check return to IDLE.
  task automatic run_frame(input bit msb, input logic [7:0] word, input logic [7:0] seq,
                           input logic par, input string name);
    logic [3:0] o;
    @(negedge clk);
    drive(msb, 1'b1, word);
    check({name, "_ready"}, 8'(outs(msb) >> 3), 8'd1);
    @(negedge clk);
    drive(msb, 1'b0, 8'($urandom));
    for (int i = 0; i < FL; i++) begin
      o = outs(msb);
      check($sformatf("%s_bit%0d", name, i), 8'(o),
            8'({(i == FL-1), 1'b1, exp_bit(seq, par, i), (i == FL-1)}));
      @(negedge clk);
    end
    check_idle(msb, {name, "_idle"});
  endtask

  initial begin
    vecs[0] = '{msb: 1'b0, word: 8'b11011101, seq: 8'b11011101, par: 1'b0};
    vecs[1] = '{msb: 1'b0, word: 8'h01,       seq: 8'b00000001, par: 1'b1};
    vecs[2] = '{msb: 1'b0, word: 8'hA5,       seq: 8'b10100101, par: 1'b0};
    vecs[3] = '{msb: 1'b1, word: 8'h81,       seq: 8'b10000001, par: 1'b0};
    vecs[4] = '{msb: 1'b1, word: 8'hC4,       seq: 8'b00100011, par: 1'b1};

    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(1'b0, "reset_l");
    check_idle(1'b1, "reset_m");
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check_idle(1'b0, "post_reset_l");

    foreach (vecs[k])
      run_frame(vecs[k].msb, vecs[k].word, vecs[k].seq, vecs[k].par, $sformatf("vec%0d", k));

    // Back-to-back: A5 then 3C with load_valid held, no gap between frames.
    begin
      logic [7:0] s1, s2;
      logic [3:0] o;
      s1 = 8'hA5; s2 = 8'h3C;
      done_cnt = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'hA5);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h3C);
      for (int i = 0; i < FL; i++) begin
        o = outs(1'b0);
        if (o[0]) done_cnt++;
        check($sformatf("b2b_a_bit%0d", i), 8'(o[3:1]),
              8'({(i == FL-1), 1'b1, exp_bit(s1, 1'b0, i)}));
        @(negedge clk);
      end
      drive(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < FL; i++) begin
        o = outs(1'b0);
        if (o[0]) done_cnt++;
        check($sformatf("b2b_b_bit%0d", i), 8'(o[2:1]), 8'({1'b1, exp_bit(s2, 1'b0, i)}));
        @(negedge clk);
      end
      check("b2b_done_count", 8'(done_cnt), 8'd2);
      check_idle(1'b0, "b2b_idle");
    end

    // load_valid mid-frame is ignored while ready is low.
    begin
      logic [3:0] o;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h00);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < FL; i++) begin
        if (i == 3) drive(1'b0, 1'b1, 8'hFF);
        if (i == 4) drive(1'b0, 1'b0, 8'h00);
        o = outs(1'b0);
        if (i == 3) check("ignore_ready_low", 8'(o[3]), 8'd0);
        check($sformatf("ignore_bit%0d", i), 8'(o[2:1]), 8'b10);
        @(negedge clk);
      end
      check_idle(1'b0, "ignore_idle");
      @(negedge clk);
      check_idle(1'b0, "ignore_idle2");
    end

    // Reset mid-frame aborts it.
    begin
      @(negedge clk);
      drive(1'b0, 1'b1, 8'hDD);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00);
      repeat (4) @(negedge clk);
      check("abort_pre_bit4", 8'(outs(1'b0) >> 1), 8'b011);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_idle(1'b0, "abort_now");
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check($sformatf("abort_quiet%0d", i), 8'(outs(1'b0)), 8'b1000);
      end
    end

    // Deserialise MSB-first 8'h81 as a downstream sipo would.
    begin
      logic [7:0] acc;
      acc = '0;
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h81);
      @(negedge clk);
      drive(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
        if (bus_m.dout_valid) acc = {acc[6:0], bus_m.dataout};
        @(negedge clk);
      end
      check("sipo_chain", acc, 8'h81);
      repeat (FL - 8) @(negedge clk);
      check_idle(1'b1, "sipo_idle");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
